probe_capture_ctrl: RTL and testbench

Trigger-and-capture sequencer for the debug probe datapath. Arms on request, watches a 13-bit trigger bus against a value/mask, stores a configurable number of valid 64-bit probe samples starting at the trigger sample, then streams them out over a valid/ready read port. Sits between the probe sampling registers and the debug readout/host interface.

---
 rtl/probe_ctrl_pkg.sv | 20 ++
 rtl/probe_sample_buf.sv | 22 ++
 rtl/probe_capture_ctrl.sv | 147 ++++++++++++++
 tb/tb_probe_capture_ctrl.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/probe_ctrl_pkg.sv
// Shared types and sizing helpers for the probe trigger/capture controller.
package probe_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      READOUT = 2'd3
   } state_t;

   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

   // Zero or oversize requests capture a full buffer.
   function automatic int eff_len(input int cap, input int depth);
      return ((cap == 0) || (cap > depth)) ? depth : cap;
   endfunction

endpackage

// File: rtl/probe_sample_buf.sv
// Capture storage: DEPTH x WIDTH register array, one write port, one async read port.
module probe_sample_buf #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/probe_capture_ctrl.sv
// Trigger-and-capture sequencer: arm, match trigger, store L samples, stream them out.
//
// state   | meaning
// IDLE    | waiting for arm
// ARMED   | config latched, comparing trigger bus on each valid sample
// CAPTURE | trigger seen, writing following valid samples until L stored
// READOUT | presenting stored entries on the valid/ready read port
module probe_capture_ctrl
   import probe_ctrl_pkg::*;
#(
   parameter int WIDTH  = 64,
   parameter int TRIG_W = 13,
   parameter int DEPTH  = 16
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     arm,
   input  logic                     abort,
   input  logic [$clog2(DEPTH):0]   cap_len,
   input  logic [TRIG_W-1:0]        trig_value,
   input  logic [TRIG_W-1:0]        trig_mask,
   input  logic [WIDTH-1:0]         sample_in,
   input  logic                     sample_vld,
   input  logic [TRIG_W-1:0]        trig_in,
   output logic [WIDTH-1:0]         rd_data,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic                     rd_last,
   output logic                     busy,
   output logic                     triggered,
   output logic                     done
);

   localparam int CNT_W = cnt_w(DEPTH);
   localparam int AW    = $clog2(DEPTH);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   len_q;
   logic [TRIG_W-1:0]  trig_value_q, trig_mask_q;
   logic [CNT_W-1:0]   wr_cnt_q, wr_cnt_d;
   logic [CNT_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic               done_q, done_d;
   logic               buf_we;
   logic [AW-1:0]      buf_waddr;
   logic [WIDTH-1:0]   buf_rdata;
   logic [CNT_W-1:0]   last_idx;
   logic               match;
   logic               rd_last_i;
   logic               do_arm;

   assign last_idx  = len_q - CNT_W'(1);
   assign match     = sample_vld && (((trig_in ^ trig_value_q) & trig_mask_q) == '0);
   assign rd_last_i = (state_q == READOUT) && (rd_ptr_q == last_idx);
   assign do_arm    = (state_q == IDLE) && arm && !abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         len_q        <= '0;
         trig_value_q <= '0;
         trig_mask_q  <= '0;
         wr_cnt_q     <= '0;
         rd_ptr_q     <= '0;
         done_q       <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         rd_ptr_q <= rd_ptr_d;
         done_q   <= done_d;
         if (do_arm) begin
            len_q        <= CNT_W'(eff_len(int'(cap_len), DEPTH));
            trig_value_q <= trig_value;
            trig_mask_q  <= trig_mask;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      wr_cnt_d  = wr_cnt_q;
      rd_ptr_d  = rd_ptr_q;
      done_d    = 1'b0;
      buf_we    = 1'b0;
      buf_waddr = wr_cnt_q[AW-1:0];
      case (state_q)
         IDLE: begin
            if (do_arm) begin
               state_d  = ARMED;
               wr_cnt_d = '0;
               rd_ptr_d = '0;
            end
         end
         ARMED: begin
            if (abort) begin
               state_d = IDLE;
            end else if (match) begin
               buf_we    = 1'b1;
               buf_waddr = '0;
               wr_cnt_d  = CNT_W'(1);
               state_d   = (len_q == CNT_W'(1)) ? READOUT : CAPTURE;
            end
         end
         CAPTURE: begin
            if (abort) begin
               state_d = IDLE;
            end else if (sample_vld) begin
               buf_we   = 1'b1;
               wr_cnt_d = wr_cnt_q + CNT_W'(1);
               if (wr_cnt_q == last_idx) state_d = READOUT;
            end
         end
         READOUT: begin
            if (abort) begin
               state_d = IDLE;
            end else if (rd_ready) begin
               rd_ptr_d = rd_ptr_q + CNT_W'(1);
               if (rd_last_i) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   probe_sample_buf #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_buf (
      .clk   (clk),
      .we    (buf_we),
      .waddr (buf_waddr),
      .wdata (sample_in),
      .raddr (rd_ptr_q[AW-1:0]),
      .rdata (buf_rdata)
   );

   // Buffer is not reset, so the read data is gated to keep outputs at zero outside READOUT.
   assign rd_valid  = (state_q == READOUT);
   assign rd_data   = rd_valid ? buf_rdata : '0;
   assign rd_last   = rd_last_i;
   assign busy      = (state_q != IDLE);
   assign triggered = (state_q == CAPTURE) || (state_q == READOUT);
   assign done      = done_q;

endmodule

// File: tb/tb_probe_capture_ctrl.sv
// Directed-random bench for probe_capture_ctrl with a capture-queue reference model.
module tb_probe_capture_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        arm = 1'b0;
   logic        abort = 1'b0;
   logic [4:0]  cap_len = '0;
   logic [12:0] trig_value = '0;
   logic [12:0] trig_mask = '0;
   logic [63:0] sample_in = '0;
   logic        sample_vld = 1'b0;
   logic [12:0] trig_in = '0;
   logic [63:0] rd_data;
   logic        rd_valid;
   logic        rd_ready = 1'b0;
   logic        rd_last;
   logic        busy;
   logic        triggered;
   logic        done;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] expq [$];

   probe_capture_ctrl #(.WIDTH(64), .TRIG_W(13), .DEPTH(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .arm        (arm),
      .abort      (abort),
      .cap_len    (cap_len),
      .trig_value (trig_value),
      .trig_mask  (trig_mask),
      .sample_in  (sample_in),
      .sample_vld (sample_vld),
      .trig_in    (trig_in),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .rd_ready   (rd_ready),
      .rd_last    (rd_last),
      .busy       (busy),
      .triggered  (triggered),
      .done       (done)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Arms, then drives valid samples (with optional gaps) until the model says L are stored.
   task automatic run_capture(input int cl, input logic [12:0] val, input logic [12:0] mask,
                              input int match_at, input int gap, input int abort_at,
                              input bit idx_data);
      int          len;
      int          idx;
      int          cap;
      logic [12:0] t;
      logic [63:0] d;
      len = ((cl == 0) || (cl > 16)) ? 16 : cl;
      expq.delete();
      cap_len    = 5'(cl);
      trig_value = val;
      trig_mask  = mask;
      arm        = 1'b1;
      step();
      arm        = 1'b0;
      cap_len    = 5'($urandom);
      trig_value = 13'($urandom);
      trig_mask  = 13'($urandom);
      chk("arm_busy", busy, 1);
      chk("arm_trig", triggered, 0);
      idx = 0;
      cap = 0;
      while (cap < len) begin
         for (int g = 0; g < gap && idx > 0; g++) begin
            sample_vld = 1'b0;
            trig_in    = val;
            sample_in  = {$urandom, $urandom};
            step();
            chk("gap_trig", triggered, 64'(cap > 0));
            chk("gap_rdv", rd_valid, 0);
         end
         d = idx_data ? 64'(idx) : {$urandom, $urandom};
         if (idx < match_at) begin
            t = 13'($urandom);
            if (((t ^ val) & mask) == '0) t = t ^ (mask & (~mask + 13'd1));
         end else if (idx == match_at) begin
            t = (val & mask) | (13'($urandom) & ~mask);
         end else begin
            t = 13'($urandom);
         end
         sample_vld = 1'b1;
         sample_in  = d;
         trig_in    = t;
         if (abort_at >= 0 && cap == abort_at) begin
            abort = 1'b1;
            step();
            abort      = 1'b0;
            sample_vld = 1'b0;
            chk("abort_busy", busy, 0);
            chk("abort_trig", triggered, 0);
            chk("abort_rdv", rd_valid, 0);
            chk("abort_done", done, 0);
            for (int k = 0; k < 4; k++) begin
               step();
               chk("post_abort_rdv", rd_valid, 0);
               chk("post_abort_done", done, 0);
               chk("post_abort_busy", busy, 0);
            end
            return;
         end
         step();
         if (idx >= match_at) begin
            expq.push_back(d);
            cap++;
         end
         idx++;
         chk("cap_trig", triggered, 64'(cap > 0));
         chk("cap_rdv", rd_valid, 64'(cap == len));
         chk("cap_busy", busy, 1);
      end
      sample_vld = 1'b0;
   endtask

   task automatic readout(input bit stall3, input bit arm_noise, input int stop_after);
      int len;
      int i;
      int cyc;
      len = expq.size();
      i   = 0;
      cyc = 0;
      while (i < len) begin
         if (stop_after >= 0 && i == stop_after) return;
         if (cyc >= 300) begin
            chk("readout_timeout", 64'(i), 64'(len));
            return;
         end
         rd_ready   = (stall3 && cyc < 3) ? 1'b0 : (($urandom % 4) != 0);
         arm        = arm_noise ? 1'($urandom) : 1'b0;
         sample_vld = 1'($urandom);
         sample_in  = {$urandom, $urandom};
         trig_in    = 13'($urandom);
         chk("rd_valid", rd_valid, 1);
         chk("rd_data", rd_data, expq[i]);
         chk("rd_last", rd_last, 64'(i == len - 1));
         chk("rd_done_low", done, 0);
         chk("rd_trig", triggered, 1);
         step();
         if (rd_ready) i++;
         cyc++;
      end
      rd_ready   = 1'b0;
      arm        = 1'b0;
      sample_vld = 1'b0;
      chk("done_pulse", done, 1);
      chk("done_rdv", rd_valid, 0);
      chk("done_busy", busy, 0);
      chk("done_trig", triggered, 0);
      chk("done_last", rd_last, 0);
      step();
      chk("done_clear", done, 0);
      chk("idle_busy", busy, 0);
   endtask

   initial begin
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_trig", triggered, 0);
      chk("rst_rdv", rd_valid, 0);
      chk("rst_done", done, 0);
      chk("rst_data", rd_data, 0);
      #10 rst_n = 1'b1;
      step();
      chk("post_rst_busy", busy, 0);

      run_capture(4, 13'h0ABC, 13'h1FFF, 4, 0, -1, 1'b1);
      chk("t1_first", expq[0], 64'd4);
      readout(1'b0, 1'b0, -1);

      run_capture(2, 13'($urandom), 13'h0000, 0, 3, -1, 1'b0);
      readout(1'b0, 1'b0, -1);

      run_capture(5, 13'($urandom), 13'($urandom) | 13'h1, 3, 1, -1, 1'b0);
      readout(1'b1, 1'b0, -1);

      run_capture(8, 13'($urandom), 13'h1FFF, 2, 0, 2, 1'b0);
      run_capture(3, 13'($urandom), 13'h00F0, 1, 2, -1, 1'b0);
      readout(1'b0, 1'b0, -1);

      run_capture(0, 13'($urandom), 13'h1FFF, 2, 0, -1, 1'b0);
      chk("len0_entries", 64'(expq.size()), 64'd16);
      readout(1'b0, 1'b1, -1);
      run_capture(20, 13'($urandom), 13'h0F0F, 1, 1, -1, 1'b0);
      readout(1'b0, 1'b1, -1);

      run_capture(1, 13'($urandom), 13'h1FFF, 3, 0, -1, 1'b0);
      readout(1'b1, 1'b0, -1);

      run_capture(6, 13'($urandom), 13'h1FFF, 0, 0, -1, 1'b0);
      readout(1'b0, 1'b0, 2);
      rd_ready = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk("arst_rdv", rd_valid, 0);
      chk("arst_busy", busy, 0);
      chk("arst_trig", triggered, 0);
      chk("arst_last", rd_last, 0);
      chk("arst_data", rd_data, 0);
      #2 rst_n = 1'b1;
      step();
      chk("arst_idle", busy, 0);
      chk("arst_idle_rdv", rd_valid, 0);

      arm   = 1'b1;
      abort = 1'b1;
      step();
      arm   = 1'b0;
      abort = 1'b0;
      chk("arm_abort_idle", busy, 0);

      run_capture(3, 13'($urandom), 13'h1FFF, 1, 0, -1, 1'b0);
      readout(1'b0, 1'b1, -1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
